// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, redirects and a 2-entry {pc, instr} queue to decode.
// Optional FETCH_EBREAK_HALT_EN: stop fetching once an EBREAK has been queued.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        busy,
  output logic        fault
);

  localparam logic [32:0] PcLimit = 33'(IMEM_WORDS) * 33'd4;
  localparam logic [31:0] Ebreak  = 32'h0010_0073;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;
  logic        fault_q, fault_d;

  logic run, redir, misaligned, oob, pop, push, halt_req;

  assign run        = (state_q == StRun);
  assign redir      = run & redirect_valid;
  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign oob        = ({1'b0, pc_q} >= PcLimit);
  // Redirect owns the cycle: no pop, no push.
  assign pop        = (count_q != 2'd0) & out_ready & ~redir;
  assign push       = run & ~redir & ~oob & ((count_q != 2'd2) | pop);

`ifdef FETCH_EBREAK_HALT_EN
  assign halt_req = push & (imem_rd == Ebreak);
`else
  assign halt_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun: begin
        if ((redir & misaligned) | (~redir & oob) | halt_req) state_d = StHalt;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = run;
    imem_addr = pc_q;
    out_valid = (count_q != 2'd0);
    out_pc    = fifo_pc_q[rd_ptr_q];
    out_instr = fifo_instr_q[rd_ptr_q];
    fault     = fault_q;
  end

  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q | (redir & misaligned) | (run & ~redir & oob);
    count_d = count_q;
    if (redir) begin
      count_d = 2'd0;
      if (!misaligned) pc_d = redirect_pc;
    end else begin
      if (push) pc_d = pc_q + 32'd4;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      fault_q  <= 1'b0;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc_q[i]    <= 32'd0;
        fifo_instr_q[i] <= 32'd0;
      end
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
      count_q <= count_d;
      if (redir) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          fifo_pc_q[wr_ptr_q]    <= pc_q;
          fifo_instr_q[wr_ptr_q] <= imem_rd;
          wr_ptr_q               <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: scoreboard of expected {pc, instr} popped as decode accepts.
// Honours FETCH_EBREAK_HALT_EN for the EBREAK expectations.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, redirect_valid, out_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rd, out_instr, out_pc;
  logic        out_valid, busy, fault;

  logic [31:0] imem [16];
  logic [63:0] exp_q [$];
  logic [63:0] exp_e;
  logic [31:0] last_pc, saved_addr;
  logic        sb_en, saw_c;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign imem_rd = (imem_addr[31:6] == 26'd0) ? imem[imem_addr[5:2]] : 32'd0;

  fetch_ctrl #(.RESET_PC(32'h0), .IMEM_WORDS(10)) dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .busy(busy), .fault(fault)
  );

  // Scoreboard: every accepted head must match the next expected entry.
  always @(negedge clk) begin
    if (sb_en && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra got pc=%h instr=%h expected nothing", out_pc, out_instr);
      end else begin
        exp_e = exp_q.pop_front();
        if ({out_pc, out_instr} !== exp_e) begin
          errors++;
          $display("FAIL sb_entry got pc=%h instr=%h expected pc=%h instr=%h",
                   out_pc, out_instr, exp_e[63:32], exp_e[31:0]);
        end
      end
      last_pc = out_pc;
      if (out_pc == 32'hC) saw_c = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
    sb_en = 1'b0; saw_c = 1'b0; last_pc = 32'hFFFF_FFFF;
    exp_q.delete();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_expected(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({32'(i * 4), imem[i]});
  endtask

  task automatic wait_fault_and_drain(input string name);
    for (int n = 0; n < 60 && !fault; n++) tick();
    for (int n = 0; n < 4; n++) tick();
    checks++;
    if (fault !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_halt got fault=%b busy=%b expected fault=1 busy=0", name, fault, busy);
    end
    checks++;
    if (exp_q.size() != 0 || last_pc !== 32'h24) begin
      errors++;
      $display("FAIL %s_drain got left=%0d last_pc=%h expected left=0 last_pc=00000024",
               name, exp_q.size(), last_pc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || fault !== 1'b0 || imem_addr !== 32'h0 ||
        out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got v=%b b=%b f=%b addr=%h pc=%h instr=%h expected all 0",
               out_valid, busy, fault, imem_addr, out_pc, out_instr);
    end
    // Redirect is ignored while idle.
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_addr !== 32'h0 || busy !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL idle_redirect got addr=%h busy=%b fault=%b expected 0 0 0",
               imem_addr, busy, fault);
    end
    // Fill the queue, then reset asynchronously mid-cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL prereset_full got v=%b addr=%h expected v=1 addr=00000008",
               out_valid, imem_addr);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || fault !== 1'b0 || imem_addr !== 32'h0 ||
        out_pc !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got v=%b b=%b f=%b addr=%h pc=%h expected all 0",
               out_valid, busy, fault, imem_addr, out_pc);
    end
  endtask

  task automatic test_stream();
    do_reset();
    push_expected(10);
    sb_en = 1'b1; out_ready = 1'b1; start = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_run got busy=%b v=%b expected busy=1 v=0", busy, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== imem[i]) begin
        errors++;
        $display("FAIL stream_seq%0d got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 i, out_valid, out_pc, out_instr, 32'(i * 4), imem[i]);
      end
    end
    wait_fault_and_drain("stream_oob");
    start = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    push_expected(10);
    sb_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || imem_addr !== 32'h8 || out_pc !== 32'h0) begin
      errors++;
      $display("FAIL bp_full got v=%b addr=%h pc=%h expected v=1 addr=00000008 pc=0",
               out_valid, imem_addr, out_pc);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (imem_addr !== 32'hC) begin
      errors++;
      $display("FAIL bp_release got addr=%h expected 0000000c", imem_addr);
    end
    wait_fault_and_drain("bp");
  endtask

  task automatic test_redirect();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h10; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h10 || busy !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush got v=%b addr=%h busy=%b fault=%b expected 0 00000010 1 0",
               out_valid, imem_addr, busy, fault);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== imem[4]) begin
      errors++;
      $display("FAIL redir_target got v=%b pc=%h instr=%h expected v=1 pc=00000010 instr=%h",
               out_valid, out_pc, out_instr, imem[4]);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    saved_addr = imem_addr;
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || imem_addr !== saved_addr) begin
      errors++;
      $display("FAIL misaligned got f=%b b=%b v=%b addr=%h expected 1 0 0 %h",
               fault, busy, out_valid, imem_addr, saved_addr);
    end
  endtask

  task automatic test_ebreak();
    imem[2] = 32'h0010_0073;
    do_reset();
`ifdef FETCH_EBREAK_HALT_EN
    push_expected(3);
`else
    push_expected(10);
`endif
    sb_en = 1'b1; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 60 && busy; n++) tick();
    for (int n = 0; n < 4; n++) tick();
    checks++;
`ifdef FETCH_EBREAK_HALT_EN
    if (busy !== 1'b0 || fault !== 1'b0 || saw_c !== 1'b0 || exp_q.size() != 0 ||
        last_pc !== 32'h8) begin
      errors++;
      $display("FAIL ebreak_halt got b=%b f=%b saw_c=%b left=%0d last=%h expected 0 0 0 0 8",
               busy, fault, saw_c, exp_q.size(), last_pc);
    end
`else
    if (busy !== 1'b0 || fault !== 1'b1 || saw_c !== 1'b1 || exp_q.size() != 0 ||
        last_pc !== 32'h24) begin
      errors++;
      $display("FAIL ebreak_plain got b=%b f=%b saw_c=%b left=%0d last=%h expected 0 1 1 0 24",
               busy, fault, saw_c, exp_q.size(), last_pc);
    end
`endif
    imem[2] = 32'h00A0_8113;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) imem[i] = 32'h0000_0013 + (32'(i) << 20);
    imem[0] = 32'h0000_00B3;
    imem[1] = 32'h0000_0233;
    imem[2] = 32'h00A0_8113;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_ebreak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
